// File: rtl/mem_dec_depuncture.sv
// mem_dec_depuncture
// Receive-side depuncturer. Serial coded bits from the deinterleaver are
// collected in a bit FIFO and re-formed into (A,B) pairs for the Viterbi
// branch-metric unit. For the 2/3 and 3/4 rates, punctured positions are
// re-inserted as erasures.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           frame start: clears FIFO, phase and output stage, latches rate
//   rate[3:0]       SIGNAL RATE code, sampled only while start=1
//   in_valid/in_bit serial coded bit input; in_ready = !full
//   out_valid/out_ready  output pair handshake
//   out_a, out_b    depunctured pair (an erased position reads 0)
//   out_era[1:0]    [1]=A erased, [0]=B erased
//   overflow        sticky; a bit was offered while the FIFO was full
module mem_dec_depuncture #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] rate,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_a,
  output logic       out_b,
  output logic [1:0] out_era,
  output logic       overflow
);

  typedef enum logic [1:0] {R12, R23, R34} code_rate_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic              mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [1:0]        ph_q, ph_d;
  code_rate_t        rate_q, rate_d;
  logic              out_valid_q, out_valid_d;
  logic              out_a_q, out_a_d;
  logic              out_b_q, out_b_d;
  logic [1:0]        era_q, era_d;
  logic              ovf_q, ovf_d;

  logic              full, wr, load, mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW:0]       need;
  logic [1:0]        ph_nxt;
  logic              bit0, bit1;

  function automatic code_rate_t decode_rate(input logic [3:0] code);
    case (code)
      4'b1101, 4'b0101, 4'b1001:          decode_rate = R12;
      4'b0001:                            decode_rate = R23;
      4'b1111, 4'b0111, 4'b1011, 4'b0011: decode_rate = R34;
      default:                            decode_rate = R12;
    endcase
  endfunction

  assign full     = (count_q == DEPTH_C);
  assign in_ready = !full;
  assign wr       = in_valid && !full;

  // Only the full-pair phase consumes two bits; 1/2 rate never leaves ph 0.
  assign need = (ph_q == 2'd0) ? (AW+1)'(2) : (AW+1)'(1);
  assign load = !start && (count_q >= need) && (!out_valid_q || out_ready);

  assign bit0 = mem_q[rptr_q];
  assign bit1 = mem_q[rptr_q + 1'b1];

  always_comb begin
    ph_nxt = 2'd0;
    case (rate_q)
      R23:     ph_nxt = (ph_q == 2'd0) ? 2'd1 : 2'd0;
      R34:     ph_nxt = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
      default: ph_nxt = 2'd0;
    endcase
  end

  // A bit arriving with start becomes bit 0 of the new frame.
  assign mem_we    = start ? in_valid : wr;
  assign mem_waddr = start ? '0 : wptr_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    ph_d        = ph_q;
    rate_d      = rate_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    era_d       = era_q;
    ovf_d       = ovf_q;
    if (start) begin
      wptr_d      = in_valid ? AW'(1) : '0;
      rptr_d      = '0;
      count_d     = in_valid ? (AW+1)'(1) : '0;
      ph_d        = 2'd0;
      rate_d      = decode_rate(rate);
      out_valid_d = 1'b0;
      out_a_d     = 1'b0;
      out_b_d     = 1'b0;
      era_d       = 2'b00;
      ovf_d       = 1'b0;
    end else begin
      if (in_valid && full) ovf_d = 1'b1;
      if (wr) wptr_d = wptr_q + 1'b1;
      if (load) begin
        rptr_d      = rptr_q + need[AW-1:0];
        out_valid_d = 1'b1;
        ph_d        = ph_nxt;
        case (ph_q)
          2'd1:    begin out_a_d = bit0; out_b_d = 1'b0; era_d = 2'b01; end
          2'd2:    begin out_a_d = 1'b0; out_b_d = bit0; era_d = 2'b10; end
          default: begin out_a_d = bit0; out_b_d = bit1; era_d = 2'b00; end
        endcase
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      count_d = count_q + {{AW{1'b0}}, wr} - (load ? need : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= in_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ph_q        <= 2'd0;
      rate_q      <= R12;
      out_valid_q <= 1'b0;
      out_a_q     <= 1'b0;
      out_b_q     <= 1'b0;
      era_q       <= 2'b00;
      ovf_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ph_q        <= ph_d;
      rate_q      <= rate_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      era_q       <= era_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_era   = era_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mem_dec_depuncture.sv
// Scoreboard bench for mem_dec_depuncture. A queue-based reference model
// predicts every emitted pair; a separate monitor pops and compares on each
// output handshake.
module tb_mem_dec_depuncture;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic       clk;
  logic       reset, start, in_valid, in_bit, out_ready;
  logic [3:0] rate;
  logic       in_ready, out_valid, out_a, out_b, overflow;
  logic [1:0] out_era;

  mem_dec_depuncture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .rate(rate),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_era(out_era), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       a;
    logic       b;
    logic [1:0] era;
  } pair_t;

  int    errors = 0;
  int    checks = 0;
  int    pairs_seen = 0;
  pair_t exp_q[$];

  // Reference model: bit queue, pattern period and position, output-holding flag.
  bit    m_fifo[$];
  int    m_period;
  int    m_pos;
  bit    m_ov;
  bit    m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Pattern period: 1/2 -> [pair], 2/3 -> [pair, A-only], 3/4 -> [pair, A-only, B-only]
  function automatic int period_of(input logic [3:0] c);
    case (c)
      4'b0001:                            return 2;
      4'b1111, 4'b0111, 4'b1011, 4'b0011: return 3;
      default:                            return 1;
    endcase
  endfunction

  task automatic drop_held_pair();
    if (m_ov && !out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  // Predicts what happens at the coming clock edge from the current inputs.
  task automatic model_step();
    int    need;
    bit    is_full, ld;
    pair_t p;
    if (reset) begin
      drop_held_pair();
      m_fifo.delete(); m_period = 1; m_pos = 0; m_ov = 0; m_ovf = 0;
    end else if (start) begin
      drop_held_pair();
      m_fifo.delete(); m_period = period_of(rate); m_pos = 0; m_ov = 0; m_ovf = 0;
      if (in_valid) m_fifo.push_back(in_bit);
    end else begin
      need    = (m_pos == 0) ? 2 : 1;
      is_full = (m_fifo.size() == DEPTH);
      ld      = (m_fifo.size() >= need) && (!m_ov || out_ready);
      if (in_valid && is_full) m_ovf = 1;
      if (ld) begin
        case (m_pos)
          0: begin p.a = m_fifo[0]; p.b = m_fifo[1]; p.era = 2'b00; end
          1: begin p.a = m_fifo[0]; p.b = 1'b0;      p.era = 2'b01; end
          default: begin p.a = 1'b0; p.b = m_fifo[0]; p.era = 2'b10; end
        endcase
        for (int i = 0; i < need; i++) void'(m_fifo.pop_front());
        exp_q.push_back(p);
        m_ov  = 1;
        m_pos = (m_pos + 1) % m_period;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (in_valid && !is_full) m_fifo.push_back(in_bit);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("in_ready", in_ready, (m_fifo.size() != DEPTH));
    chk("overflow", overflow, m_ovf);
    chk("out_valid", out_valid, m_ov);
  endtask

  task automatic drive(input bit rst, input bit st, input logic [3:0] rt,
                       input bit iv, input bit ib, input bit ordy);
    reset = rst; start = st; rate = rt; in_valid = iv; in_bit = ib; out_ready = ordy;
    cyc();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input bit ordy);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) drive(0, 0, 4'b0000, 1, v[i], ordy);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(0, 0, 4'b0000, 0, 0, ordy);
  endtask

  // Monitor: each accepted pair must match the oldest expected pair.
  initial begin
    pair_t e, a;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        a = '{a: out_a, b: out_b, era: out_era};
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", 32'(a), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pair", 32'(a), 32'(e));
          pairs_seen++;
        end
      end
    end
  end

  initial begin
    int base;
    reset = 1; start = 0; rate = 0; in_valid = 0; in_bit = 0; out_ready = 0;
    m_period = 1; m_pos = 0; m_ov = 0; m_ovf = 0;

    drive(1, 0, 4'b0000, 0, 0, 0);
    drive(1, 0, 4'b0000, 0, 0, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_era", out_era, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);

    // 1/2 rate: latency of one cycle after the second bit.
    drive(0, 1, 4'b1101, 0, 0, 1);
    drive(0, 0, 4'b0000, 1, 1, 1);
    drive(0, 0, 4'b0000, 1, 0, 1);
    chk("lat_not_yet", out_valid, 0);
    drive(0, 0, 4'b0000, 1, 1, 1);
    chk("lat_valid", out_valid, 1);
    chk("lat_pair", {out_a, out_b, out_era}, 4'b1000);
    drive(0, 0, 4'b0000, 1, 1, 1);
    idle(3, 1);

    // 3/4 rate.
    drive(0, 1, 4'b1111, 0, 0, 1);
    send_bits(16'b1011, 4, 1);
    idle(4, 1);

    // 2/3 rate.
    drive(0, 1, 4'b0001, 0, 0, 1);
    send_bits(16'b011011, 6, 1);
    idle(4, 1);

    // Backpressure and overflow.
    drive(0, 1, 4'b1101, 0, 0, 0);
    for (int i = 0; i < 68; i++) drive(0, 0, 4'b0000, 1, 1'($urandom_range(0, 1)), 0);
    chk("full_in_ready", in_ready, 0);
    chk("ovf_set", overflow, 1);
    base = pairs_seen;
    idle(40, 1);
    chk("ovf_drain_pairs", pairs_seen - base, 33);
    chk("ovf_sticky", overflow, 1);

    // Start mid-frame with a bit on the start cycle.
    drive(0, 1, 4'b1111, 0, 0, 0);
    send_bits(16'b101, 3, 0);
    drive(0, 1, 4'b0101, 1, 1, 1);
    chk("mid_ovf", overflow, 0);
    chk("mid_out_valid", out_valid, 0);
    drive(0, 0, 4'b0000, 1, 0, 1);
    drive(0, 0, 4'b0000, 0, 0, 1);
    chk("mid_pair_valid", out_valid, 1);
    chk("mid_pair", {out_a, out_b, out_era}, 4'b1000);
    idle(3, 1);

    // Randomized traffic with random rate codes, backpressure, starts and resets.
    drive(0, 1, 4'($urandom_range(0, 15)), 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      bit r, s;
      r = ($urandom_range(0, 999) == 0);
      s = ($urandom_range(0, 149) == 0);
      drive(r, s, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < (i % 3 == 0 ? 2 : 7)));
    end

    idle(80, 1);
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
